// File: rtl/move_instr_sequencer.sv
// Fetch/execute control sequencer for the Mini SRC register-move class (mfhi, mflo, in, out).
// All datapath enables are decoded from the state register; op_q selects the T4 action.
module move_instr_sequencer #(
    parameter int unsigned      RAM_RD_CYCLES = 1,
    parameter bit               AUTO_FETCH    = 1'b0,
    parameter int unsigned      CNT_W         = 16,
    parameter int unsigned      SEL_W         = 5,
    parameter logic [SEL_W-1:0] SEL_PC        = 5'b10100,
    parameter logic [SEL_W-1:0] SEL_MDR       = 5'b10101,
    parameter logic [SEL_W-1:0] SEL_HI        = 5'b10000,
    parameter logic [SEL_W-1:0] SEL_LO        = 5'b10001,
    parameter logic [SEL_W-1:0] SEL_INPORT    = 5'b10110,
    parameter logic [4:0]       OP_IN         = 5'b10110,
    parameter logic [4:0]       OP_OUT        = 5'b10111,
    parameter logic [4:0]       OP_MFHI       = 5'b11000,
    parameter logic [4:0]       OP_MFLO       = 5'b11001
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       ir_opcode,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic             e_PC,
    output logic             incPC,
    output logic             e_MAR,
    output logic             ram_read,
    output logic             MDR_read,
    output logic             e_MDR,
    output logic             e_IR,
    output logic             Gra,
    output logic             e_Rin,
    output logic             e_Rout,
    output logic             e_OutPort,
    output logic [SEL_W-1:0] BusDataSelect
);

    typedef enum logic [2:0] {
        StIdle, StT0, StT1, StT2, StT3, StDecode, StT4, StDone
    } state_e;

    // T1 lasts wait_load+1 cycles: counter runs down to zero before leaving.
    localparam logic [3:0] WaitLoad = 4'(RAM_RD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [4:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_legal;

    assign op_legal = (op_q == OP_IN) || (op_q == OP_OUT) ||
                      (op_q == OP_MFHI) || (op_q == OP_MFLO);
    assign instr_count = count_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            wait_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            StIdle:   if (start) state_d = StT0;
            StT0: begin
                state_d = StT1;
                wait_d  = WaitLoad;
            end
            StT1: begin
                if (wait_q == '0) state_d = StT2;
                else              wait_d  = wait_q - 1'b1;
            end
            StT2:     state_d = StT3;
            StT3:     state_d = StDecode;
            StDecode: begin
                op_d    = ir_opcode;
                state_d = StT4;
            end
            StT4:     state_d = StDone;
            StDone: begin
                if (op_legal) count_d = count_q + 1'b1;
                state_d = AUTO_FETCH ? StT0 : StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        done          = 1'b0;
        illegal       = 1'b0;
        e_PC          = 1'b0;
        incPC         = 1'b0;
        e_MAR         = 1'b0;
        ram_read      = 1'b0;
        MDR_read      = 1'b0;
        e_MDR         = 1'b0;
        e_IR          = 1'b0;
        Gra           = 1'b0;
        e_Rin         = 1'b0;
        e_Rout        = 1'b0;
        e_OutPort     = 1'b0;
        BusDataSelect = '0;
        case (state_q)
            StT0: begin
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                e_PC          = 1'b1;
                incPC         = 1'b1;
            end
            StT1:     ram_read = 1'b1;
            StT2: begin
                MDR_read = 1'b1;
                e_MDR    = 1'b1;
            end
            StT3: begin
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
            end
            StT4: begin
                if (op_q == OP_MFHI) begin
                    BusDataSelect = SEL_HI;
                    Gra           = 1'b1;
                    e_Rin         = 1'b1;
                end else if (op_q == OP_MFLO) begin
                    BusDataSelect = SEL_LO;
                    Gra           = 1'b1;
                    e_Rin         = 1'b1;
                end else if (op_q == OP_IN) begin
                    BusDataSelect = SEL_INPORT;
                    Gra           = 1'b1;
                    e_Rin         = 1'b1;
                end else if (op_q == OP_OUT) begin
                    Gra       = 1'b1;
                    e_Rout    = 1'b1;
                    e_OutPort = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            StDone:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_move_instr_sequencer.sv
// Randomized bench: one manual-start instance (3 read cycles) and one auto-fetch instance
// (1 read cycle), both compared cycle by cycle against a timeline model of the sequence.
module tb_move_instr_sequencer;

    localparam int RA = 3;
    localparam int RB = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       clear, start_a, start_b;
    logic [4:0] op_a, op_b;

    logic busy_a, done_a, ill_a, pc_a, inc_a, mar_a, rr_a, mdrr_a, emdr_a, ir_a, gra_a;
    logic rin_a, rout_a, outp_a;
    logic [4:0]  sel_a;
    logic [15:0] cnt_a;
    logic busy_b, done_b, ill_b, pc_b, inc_b, mar_b, rr_b, mdrr_b, emdr_b, ir_b, gra_b;
    logic rin_b, rout_b, outp_b;
    logic [4:0]  sel_b;
    logic [15:0] cnt_b;

    logic [18:0] vec_a, vec_b;
    assign vec_a = {busy_a, done_a, ill_a, pc_a, inc_a, mar_a, rr_a, mdrr_a, emdr_a, ir_a,
                    gra_a, rin_a, rout_a, outp_a, sel_a};
    assign vec_b = {busy_b, done_b, ill_b, pc_b, inc_b, mar_b, rr_b, mdrr_b, emdr_b, ir_b,
                    gra_b, rin_b, rout_b, outp_b, sel_b};

    move_instr_sequencer #(.RAM_RD_CYCLES(RA), .AUTO_FETCH(1'b0)) dut_a (
        .clock(clock), .clear(clear), .start(start_a), .ir_opcode(op_a),
        .busy(busy_a), .done(done_a), .illegal(ill_a), .instr_count(cnt_a),
        .e_PC(pc_a), .incPC(inc_a), .e_MAR(mar_a), .ram_read(rr_a), .MDR_read(mdrr_a),
        .e_MDR(emdr_a), .e_IR(ir_a), .Gra(gra_a), .e_Rin(rin_a), .e_Rout(rout_a),
        .e_OutPort(outp_a), .BusDataSelect(sel_a)
    );

    move_instr_sequencer #(.RAM_RD_CYCLES(RB), .AUTO_FETCH(1'b1)) dut_b (
        .clock(clock), .clear(clear), .start(start_b), .ir_opcode(op_b),
        .busy(busy_b), .done(done_b), .illegal(ill_b), .instr_count(cnt_b),
        .e_PC(pc_b), .incPC(inc_b), .e_MAR(mar_b), .ram_read(rr_b), .MDR_read(mdrr_b),
        .e_MDR(emdr_b), .e_IR(ir_b), .Gra(gra_b), .e_Rin(rin_b), .e_Rout(rout_b),
        .e_OutPort(outp_b), .BusDataSelect(sel_b)
    );

    int checks;
    int errors;
    int cnt_a_m;
    int cnt_b_m;
    logic [4:0] ops_b [5];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'b10110, 5'b10111, 5'b11000, 5'b11001};
    endfunction

    function automatic logic [4:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 5'b10110;
            1:       return 5'b10111;
            2:       return 5'b11000;
            3:       return 5'b11001;
            default: return 5'($urandom);
        endcase
    endfunction

    // Expected outputs j cycles after the start-accepting edge (j=0: idle).
    function automatic logic [18:0] exp_vec(input int j, input int r, input logic [4:0] op);
        logic b = 1'b0, d = 1'b0, il = 1'b0, pc = 1'b0, inc = 1'b0, mar = 1'b0, rr = 1'b0;
        logic mr = 1'b0, em = 1'b0, eir = 1'b0, gra = 1'b0, rin = 1'b0, rout = 1'b0;
        logic outp = 1'b0;
        logic [4:0] sel = 5'b0;
        if (j >= 1 && j <= 6 + r) b = 1'b1;
        if (j == 1) begin
            sel = 5'b10100; mar = 1'b1; pc = 1'b1; inc = 1'b1;
        end else if (j >= 2 && j <= 1 + r) begin
            rr = 1'b1;
        end else if (j == 2 + r) begin
            mr = 1'b1; em = 1'b1;
        end else if (j == 3 + r) begin
            sel = 5'b10101; eir = 1'b1;
        end else if (j == 5 + r) begin
            case (op)
                5'b11000: begin sel = 5'b10000; gra = 1'b1; rin = 1'b1; end
                5'b11001: begin sel = 5'b10001; gra = 1'b1; rin = 1'b1; end
                5'b10110: begin sel = 5'b10110; gra = 1'b1; rin = 1'b1; end
                5'b10111: begin gra = 1'b1; rout = 1'b1; outp = 1'b1; end
                default:  il = 1'b1;
            endcase
        end else if (j == 6 + r) begin
            d = 1'b1;
        end
        return {b, d, il, pc, inc, mar, rr, mr, em, eir, gra, rin, rout, outp, sel};
    endfunction

    // Entry: dut_a idle with start_a low. Exit: dut_a idle again.
    task automatic run_a(input logic [4:0] op, input int gap);
        for (int g = 0; g < gap; g++) begin
            start_a = 1'b0;
            op_a    = 5'($urandom);
            tick();
            check_eq("a_gap_idle", 32'(vec_a), 32'd0);
        end
        start_a = 1'b1;
        op_a    = 5'($urandom);
        tick();
        for (int j = 1; j <= 6 + RA; j++) begin
            check_eq($sformatf("a_seq op=%b j=%0d", op, j), 32'(vec_a), 32'(exp_vec(j, RA, op)));
            start_a = 1'($urandom_range(0, 1));
            op_a    = (j == 4 + RA) ? op : 5'($urandom);
            tick();
        end
        if (is_legal(op)) cnt_a_m++;
        check_eq("a_after_idle", 32'(vec_a), 32'd0);
        check_eq("a_count", 32'(cnt_a), 32'(cnt_a_m & 16'hFFFF));
        start_a = 1'b0;
    endtask

    // Entry: dut_b in T0 of instruction 0 (cycle c=1). Exit: at cycle n+1.
    task automatic run_b(input int n);
        int p;
        int phase;
        int txn;
        p = 6 + RB;
        for (int c = 1; c <= n; c++) begin
            phase = (c - 1) % p + 1;
            txn   = (c - 1) / p;
            if (phase == 1 && txn > 0 && is_legal(ops_b[txn-1])) cnt_b_m++;
            check_eq($sformatf("b_seq txn=%0d ph=%0d", txn, phase), 32'(vec_b),
                     32'(exp_vec(phase, RB, ops_b[txn])));
            if (phase == 1) check_eq("b_count", 32'(cnt_b), 32'(cnt_b_m & 16'hFFFF));
            start_b = 1'($urandom_range(0, 1));
            op_b    = (phase == 4 + RB) ? ops_b[txn] : 5'($urandom);
            tick();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cnt_a_m = 0;
        cnt_b_m = 0;

        clear   = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        op_a    = 5'b11001;
        op_b    = 5'b11000;
        tick();
        tick();
        check_eq("rst_vec_a", 32'(vec_a), 32'd0);
        check_eq("rst_vec_b", 32'(vec_b), 32'd0);
        check_eq("rst_cnt_a", 32'(cnt_a), 32'd0);
        check_eq("rst_cnt_b", 32'(cnt_b), 32'd0);
        clear   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        run_a(5'b11001, 0);
        run_a(5'b10111, 1);
        run_a(5'b00011, 2);
        run_a(5'b10110, 0);
        for (int i = 0; i < 12; i++) run_a(pick_op(), $urandom_range(0, 3));

        ops_b[0] = 5'b11000;
        ops_b[1] = 5'b10110;
        for (int i = 2; i < 5; i++) ops_b[i] = pick_op();
        start_b = 1'b1;
        tick();
        run_b(4 * (6 + RB) + 1);
        check_eq("b_in_t1", 32'(vec_b), 32'(exp_vec(2, RB, ops_b[4])));

        // Clear while dut_b is in T1 with start held high.
        clear   = 1'b1;
        start_b = 1'b1;
        tick();
        cnt_a_m = 0;
        cnt_b_m = 0;
        check_eq("clr_vec_b", 32'(vec_b), 32'd0);
        check_eq("clr_cnt_b", 32'(cnt_b), 32'd0);
        check_eq("clr_vec_a", 32'(vec_a), 32'd0);
        check_eq("clr_cnt_a", 32'(cnt_a), 32'd0);
        clear = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) ops_b[i] = pick_op();
        run_b(2 * (6 + RB));
        if (is_legal(ops_b[1])) cnt_b_m++;
        check_eq("b_count_end", 32'(cnt_b), 32'(cnt_b_m & 16'hFFFF));
        clear   = 1'b1;
        start_b = 1'b0;
        tick();
        clear = 1'b0;
        check_eq("b_stopped", 32'(vec_b), 32'd0);

        run_a(5'b11000, 0);
        run_a(pick_op(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
